// File: rtl/dcpu_pkg.sv
// Shared fetch-side types and constants for the dcpu front end.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package dcpu_pkg;

   localparam int XLEN       = 32;           // data / address width
   localparam int INSTR_PC_W = 2 * XLEN;     // {instr, pc} bundle width
   localparam logic [3:0] REG_PC = 4'd15;    // architectural PC register index

   // Fetch FSM encodings
   typedef enum logic [1:0] {
      FETCH_IDLE    = 2'd0,   // nothing outstanding on the memory bus
      FETCH_REQ     = 2'd1,   // request outstanding, data will be kept
      FETCH_DISCARD = 2'd2    // request outstanding, data will be dropped
   } fetch_state_t;

   // One prefetched instruction tagged with the address it came from
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } instr_pc_t;

   // Force an address onto a word boundary
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's memory bus, instruction output and redirect input.
// Latency: n/a (wiring only).
// Backpressure: memory side is request/ack, instruction side is valid/ready.
// Ports (master = fetch stage):
//   memory bus : o_memaccess, o_memaddr -> ; <- i_memdata, i_memack
//   instr bus  : o_instr_valid, o_instr, o_instr_pc -> ; <- i_instr_ready
//   redirect   : <- i_redirect, i_redirect_pc
interface instr_fetch_if;
   import dcpu_pkg::*;

   logic            o_memaccess;
   logic [XLEN-1:0] o_memaddr;
   logic [XLEN-1:0] i_memdata;
   logic            i_memack;

   logic            o_instr_valid;
   logic [XLEN-1:0] o_instr;
   logic [XLEN-1:0] o_instr_pc;
   logic            i_instr_ready;

   logic            i_redirect;
   logic [XLEN-1:0] i_redirect_pc;

   modport master (
      output o_memaccess, o_memaddr, o_instr_valid, o_instr, o_instr_pc,
      input  i_memdata, i_memack, i_instr_ready, i_redirect, i_redirect_pc
   );

   modport slave (
      input  o_memaccess, o_memaddr, o_instr_valid, o_instr, o_instr_pc,
      output i_memdata, i_memack, i_instr_ready, i_redirect, i_redirect_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with a registered head word and flush.
// Latency: a push into an empty buffer is visible at the head one cycle later.
// Backpressure: caller must not push when full unless popping the same cycle.
// Ports: i_clk, i_reset (async, active-high); push/push_dat, pop, flush in;
//        head_dat/head_vld, count, full, empty out.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_dat,
   output logic                     head_vld,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr, rd_nxt;
   logic [CW-1:0]    cnt_q, cnt_after_pop, cnt_nxt;
   logic [WIDTH-1:0] head_q, head_nxt;
   logic             vld_q;
   logic             pop_eff;

   assign pop_eff = pop && (cnt_q != '0);

   // The head is kept in its own register; work out what will sit at the
   // read pointer after this cycle. If the buffer drains to nothing before
   // the push lands, the pushed word becomes the head directly.
   always_comb begin
      rd_nxt        = rd_ptr;
      if (pop_eff)
         rd_nxt     = rd_ptr + PW'(1);
      cnt_after_pop = cnt_q - CW'(pop_eff);
      cnt_nxt       = cnt_after_pop + CW'(push);
      head_nxt      = (cnt_after_pop == '0) ? push_dat : mem[rd_nxt];
   end

   always_ff @(posedge i_clk) begin
      if (push && !flush)
         mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt_q  <= '0;
         head_q <= '0;
         vld_q  <= 1'b0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         rd_ptr <= rd_nxt;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         cnt_q  <= cnt_nxt;
         head_q <= head_nxt;
         vld_q  <= (cnt_nxt != '0);
      end
   end

   assign head_dat = head_q;
   assign head_vld = vld_q;
   assign count    = cnt_q;
   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);

   // The fetch FSM reserves a slot before it issues, so this never fires.
   a_no_overflow : assert property (@(posedge i_clk) disable iff (i_reset)
      !(push && full && !pop));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the fetch PC, issues single-outstanding word reads, queues words for ctrlunit.
// Latency: ack in cycle N gives o_instr_valid in cycle N+1 when the buffer was empty.
// Backpressure: no request is issued unless a buffer slot is free; i_instr_ready drains the head.
// Ports: i_clk, i_reset (async, active-high), bus (instr_fetch_if.master):
//        memory request/ack, instruction valid/ready with PC tag, redirect pulse + target.
module instr_fetch
   import dcpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int              DEPTH     = 2,
   parameter logic [XLEN-1:0] ADDR_STEP = 32'd4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   instr_fetch_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t    state;
   logic [XLEN-1:0] fetch_pc;
   logic            memaccess_q;
   logic [XLEN-1:0] memaddr_q;

   logic [CW-1:0]   fifo_count;
   logic            fifo_full, fifo_empty, fifo_vld;
   instr_pc_t       head, push_word;

   logic            ack, push, pop;
   logic [CW-1:0]   cnt_after;
   logic            space_after;
   logic [XLEN-1:0] redirect_pc, next_pc;

   // An ack only counts while a request is actually outstanding.
   assign ack         = bus.i_memack && (state != FETCH_IDLE);
   // A redirect wins over both a consume and a keep-worthy ack.
   assign pop         = fifo_vld && bus.i_instr_ready && !bus.i_redirect;
   assign push        = (state == FETCH_REQ) && ack && !bus.i_redirect;
   assign cnt_after   = fifo_count + CW'(push) - CW'(pop);
   assign space_after = (cnt_after < CW'(DEPTH));
   assign redirect_pc = word_align(bus.i_redirect_pc);
   assign next_pc     = fetch_pc + ADDR_STEP;   // wraps mod 2^32
   assign push_word   = '{instr: bus.i_memdata, pc: fetch_pc};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= FETCH_IDLE;
         fetch_pc    <= RESET_PC;
         memaccess_q <= 1'b0;
         memaddr_q   <= RESET_PC;
      end else if (bus.i_redirect) begin
         fetch_pc <= redirect_pc;
         case (state)
            FETCH_REQ, FETCH_DISCARD: begin
               if (ack) begin
                  // Bus is free this edge: start the new stream straight away.
                  state       <= FETCH_REQ;
                  memaccess_q <= 1'b1;
                  memaddr_q   <= redirect_pc;
               end else begin
                  // Old request cannot be withdrawn; swallow its data later.
                  state <= FETCH_DISCARD;
               end
            end
            default: begin
               state       <= FETCH_REQ;
               memaccess_q <= 1'b1;
               memaddr_q   <= redirect_pc;
            end
         endcase
      end else begin
         case (state)
            FETCH_IDLE: begin
               // A pop from a full buffer frees the slot this same cycle.
               if (!fifo_full || pop) begin
                  state       <= FETCH_REQ;
                  memaccess_q <= 1'b1;
                  memaddr_q   <= fetch_pc;
               end
            end
            FETCH_REQ: begin
               if (ack) begin
                  fetch_pc  <= next_pc;
                  memaddr_q <= next_pc;
                  if (!space_after) begin
                     state       <= FETCH_IDLE;
                     memaccess_q <= 1'b0;
                  end
               end
            end
            FETCH_DISCARD: begin
               if (ack) begin
                  state       <= FETCH_REQ;
                  memaccess_q <= 1'b1;
                  memaddr_q   <= fetch_pc;
               end
            end
            default: begin
               state       <= FETCH_IDLE;
               memaccess_q <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_PC_W)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .push     (push),
      .push_dat (push_word),
      .pop      (pop),
      .flush    (bus.i_redirect),
      .head_dat (head),
      .head_vld (fifo_vld),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign bus.o_memaccess   = memaccess_q;
   assign bus.o_memaddr     = memaddr_q;
   assign bus.o_instr_valid = fifo_vld;
   assign bus.o_instr       = head.instr;
   assign bus.o_instr_pc    = head.pc;

   // The registered valid bit and the occupancy count must always agree.
   a_vld_consistent : assert property (@(posedge i_clk) disable iff (i_reset)
      fifo_vld == !fifo_empty);

   // The request line is a pure decode of the state register.
   a_access_matches_state : assert property (@(posedge i_clk) disable iff (i_reset)
      memaccess_q == (state != FETCH_IDLE));

endmodule
